// File: rtl/gtech_scan_ctrl.sv
// Scan-chain driver: loads a pattern through TE/TI, runs CAP_CYCLES functional edges,
// then unloads the chain via SO. Optional compare against EXP with SCAN_CTRL_CMP_EN.
module gtech_scan_ctrl #(
  parameter int unsigned CHAIN_LEN  = 8,
  parameter int unsigned CAP_CYCLES = 1
) (
  input  logic                 i_cp,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [CHAIN_LEN-1:0] i_pat,
`ifdef SCAN_CTRL_CMP_EN
  input  logic [CHAIN_LEN-1:0] i_exp,
  output logic                 o_mismatch,
  output logic [CHAIN_LEN-1:0] o_errmap,
`endif
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CHAIN_LEN-1:0] o_result,
  output logic                 o_te,
  output logic                 o_ti,
  input  logic                 i_so
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned CAP_W = $clog2(CAP_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CAPT, S_UNLD, S_DONE} state_t;

  state_t               r_state, w_state_nx;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nx;
  logic [CAP_W-1:0]     r_cap, w_cap_nx;
  logic [CHAIN_LEN-1:0] r_shift, w_shift_nx;
  logic [CHAIN_LEN-1:0] r_result, w_result_nx;
  logic                 r_te, w_te_nx;
  logic                 r_ti, w_ti_nx;
  logic                 r_busy, w_busy_nx;
  logic                 r_done, w_done_nx;
  logic                 w_accept;
  logic [CHAIN_LEN-1:0] w_shr;
  logic [CHAIN_LEN-1:0] w_unld;

  // One register serves as the load pattern source and then as the unload collector.
  assign w_shr = r_shift >> 1;
  always_comb begin
    w_unld                = w_shr;
    w_unld[CHAIN_LEN-1]   = i_so;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_cap_nx    = r_cap;
    w_shift_nx  = r_shift;
    w_result_nx = r_result;
    w_te_nx     = 1'b0;
    w_ti_nx     = 1'b0;
    w_busy_nx   = r_busy;
    w_done_nx   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept   = 1'b1;
          w_state_nx = S_LOAD;
          w_cnt_nx   = '0;
          w_shift_nx = i_pat >> 1;
          w_te_nx    = 1'b1;
          w_ti_nx    = i_pat[0];
          w_busy_nx  = 1'b1;
        end
      end
      S_LOAD: begin
        if (r_cnt == CNT_W'(CHAIN_LEN - 1)) begin
          w_state_nx = S_CAPT;
          w_cnt_nx   = '0;
          w_cap_nx   = '0;
        end else begin
          w_cnt_nx   = r_cnt + CNT_W'(1);
          w_te_nx    = 1'b1;
          w_ti_nx    = r_shift[0];
          w_shift_nx = w_shr;
        end
      end
      S_CAPT: begin
        if (r_cap == CAP_W'(CAP_CYCLES - 1)) begin
          w_state_nx = S_UNLD;
          w_cap_nx   = '0;
          w_cnt_nx   = '0;
          w_te_nx    = 1'b1;
        end else begin
          w_cap_nx   = r_cap + CAP_W'(1);
        end
      end
      S_UNLD: begin
        w_shift_nx = w_unld;
        if (r_cnt == CNT_W'(CHAIN_LEN - 1)) begin
          w_state_nx  = S_DONE;
          w_cnt_nx    = '0;
          w_result_nx = w_unld;
          w_busy_nx   = 1'b0;
          w_done_nx   = 1'b1;
        end else begin
          w_cnt_nx    = r_cnt + CNT_W'(1);
          w_te_nx     = 1'b1;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_cp or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_cap    <= '0;
      r_shift  <= '0;
      r_result <= '0;
      r_te     <= 1'b0;
      r_ti     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_cap    <= w_cap_nx;
      r_shift  <= w_shift_nx;
      r_result <= w_result_nx;
      r_te     <= w_te_nx;
      r_ti     <= w_ti_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
    end
  end

`ifdef SCAN_CTRL_CMP_EN
  logic [CHAIN_LEN-1:0] r_exp;
  logic                 r_mismatch;
  logic [CHAIN_LEN-1:0] r_errmap;

  // Compare results are refreshed together with RESULT so both appear in the DONE cycle.
  always_ff @(posedge i_cp or posedge i_rst) begin
    if (i_rst) begin
      r_exp      <= '0;
      r_mismatch <= 1'b0;
      r_errmap   <= '0;
    end else begin
      if (w_accept) r_exp <= i_exp;
      if (w_done_nx) begin
        r_mismatch <= (w_result_nx != r_exp);
        r_errmap   <= w_result_nx ^ r_exp;
      end
    end
  end

  assign o_mismatch = r_mismatch;
  assign o_errmap   = r_errmap;
`endif

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_te     = r_te;
  assign o_ti     = r_ti;

endmodule

// File: tb/tb_gtech_scan_ctrl.sv
// Bench: two controllers (CAP_CYCLES=1 and 2) each driving an 8-flop GTECH_FJK1S-style chain.
module tb_gtech_scan_ctrl;

  localparam int N  = 8;
  localparam int C1 = 1;
  localparam int C2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] pat = '0;
  logic jj = 1'b0, kk = 1'b0;

  logic te1, ti1, busy1, done1, so1;
  logic te2, ti2, busy2, done2, so2;
  logic [7:0] res1, res2;
  logic [7:0] ch1 = '0, ch2 = '0;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SCAN_CTRL_CMP_EN
  logic [7:0] expv = '0;
  logic mm1, mm2;
  logic [7:0] em1, em2;
`endif

  always #5 clk = ~clk;

  gtech_scan_ctrl #(.CHAIN_LEN(N), .CAP_CYCLES(C1)) u_dut1 (
    .i_cp(clk), .i_rst(rst), .i_start(start), .i_pat(pat),
`ifdef SCAN_CTRL_CMP_EN
    .i_exp(expv), .o_mismatch(mm1), .o_errmap(em1),
`endif
    .o_busy(busy1), .o_done(done1), .o_result(res1), .o_te(te1), .o_ti(ti1), .i_so(so1));

  gtech_scan_ctrl #(.CHAIN_LEN(N), .CAP_CYCLES(C2)) u_dut2 (
    .i_cp(clk), .i_rst(rst), .i_start(start), .i_pat(pat),
`ifdef SCAN_CTRL_CMP_EN
    .i_exp(expv), .o_mismatch(mm2), .o_errmap(em2),
`endif
    .o_busy(busy2), .o_done(done2), .o_result(res2), .o_te(te2), .o_ti(ti2), .i_so(so2));

  // Scan JK flop chain: TE shifts TI toward position 0, otherwise Q+ = J&~Q | ~K&Q.
  always @(posedge clk) begin
    ch1 <= te1 ? {ti1, ch1[7:1]} : ((ch1 & ~{8{kk}}) | (~ch1 & {8{jj}}));
    ch2 <= te2 ? {ti2, ch2[7:1]} : ((ch2 & ~{8{kk}}) | (~ch2 & {8{jj}}));
  end
  assign so1 = ch1[0];
  assign so2 = ch2[0];

  // Expected chain contents after c capture edges in a given J/K mode.
  function automatic logic [7:0] model(input logic [7:0] p, input logic [1:0] jk, input int c);
    case (jk)
      2'b00:   return p;
      2'b11:   return (c % 2 == 1) ? ~p : p;
      2'b10:   return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expct);
    n_checks++;
    assert (obs === expct) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expct);
    end
  endtask

  task automatic chk_cycle(input string id, input int c, input int cc, input logic [7:0] p,
                           input logic [7:0] m, input logic te, input logic ti,
                           input logic busy, input logic done, input logic [7:0] res);
    int last;
    logic exp_ti;
    last   = 2 * N + cc;
    exp_ti = (c <= N) ? p[c-1] : 1'b0;
    chk({id, "_te"},   32'(te),   32'((c <= N) || (c > N + cc && c <= last)));
    chk({id, "_ti"},   32'(ti),   32'(exp_ti));
    chk({id, "_busy"}, 32'(busy), 32'(c <= last));
    chk({id, "_done"}, 32'(done), 32'(c == last + 1));
    if (c > last) chk({id, "_result"}, 32'(res), 32'(m));
  endtask

  task automatic run(input logic [7:0] p, input logic [7:0] e, input logic [1:0] jk,
                     input bit repulse);
    logic [7:0] m1, m2;
    int dc1, dc2;
    dc1 = 0; dc2 = 0;
    jj = jk[1]; kk = jk[0];
    m1 = model(p, jk, C1);
    m2 = model(p, jk, C2);
    start = 1'b1; pat = p;
`ifdef SCAN_CTRL_CMP_EN
    expv = e;
`endif
    @(posedge clk); #1;
    for (int c = 1; c <= 2 * N + C2 + 2; c++) begin
      start = repulse && (c <= 2 * N + C1 + 1);
      pat = 8'($urandom);
`ifdef SCAN_CTRL_CMP_EN
      expv = 8'($urandom);
      if (c == 2 * N + C1 + 1) begin
        chk("d1_mismatch", 32'(mm1), 32'(m1 != e));
        chk("d1_errmap",   32'(em1), 32'(m1 ^ e));
      end
      if (c == 2 * N + C2 + 1) begin
        chk("d2_mismatch", 32'(mm2), 32'(m2 != e));
        chk("d2_errmap",   32'(em2), 32'(m2 ^ e));
      end
`endif
      chk_cycle("d1", c, C1, p, m1, te1, ti1, busy1, done1, res1);
      chk_cycle("d2", c, C2, p, m2, te2, ti2, busy2, done2, res2);
      if (done1) dc1++;
      if (done2) dc2++;
      @(posedge clk); #1;
    end
    chk("d1_done_count", 32'(dc1), 32'd1);
    chk("d2_done_count", 32'(dc2), 32'd1);
    start = 1'b0;
    if (e == 8'h00) pat = 8'h00;
  endtask

  initial begin
    logic [7:0] rp;
    logic [1:0] rjk;
    int nd;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_te", 32'(te1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_te",     32'({te1, te2}),     32'd0);
    chk("idle_ti",     32'({ti1, ti2}),     32'd0);
    chk("idle_busy",   32'({busy1, busy2}), 32'd0);
    chk("idle_done",   32'({done1, done2}), 32'd0);
    chk("idle_result", 32'({res1, res2}),   32'd0);
`ifdef SCAN_CTRL_CMP_EN
    chk("idle_mismatch", 32'({mm1, mm2}), 32'd0);
    chk("idle_errmap",   32'({em1, em2}), 32'd0);
`endif

    // Directed modes: hold, toggle, set, reset.
    run(8'h3C, 8'h3D, 2'b00, 1'b0);
    run(8'h3C, 8'h3C, 2'b00, 1'b0);
    run(8'hA5, 8'h5A, 2'b11, 1'b0);
    run(8'h69, 8'hFF, 2'b10, 1'b0);
    run(8'h96, 8'h00, 2'b01, 1'b0);
    // START held high through the run, then a clean run.
    run(8'hC3, 8'hC3, 2'b00, 1'b1);
    run(8'h17, 8'h17, 2'b11, 1'b0);

    // Reset in the 4th LOAD cycle aborts both controllers.
    jj = 1'b0; kk = 1'b0;
    start = 1'b1; pat = 8'h5C;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_te", 32'({te1, te2}), 32'h3);
    chk("pre_rst_ti", 32'({ti1, ti2}), 32'h3);
    #2 rst = 1'b1;
    #1;
    chk("abort_te",     32'({te1, te2}),     32'd0);
    chk("abort_ti",     32'({ti1, ti2}),     32'd0);
    chk("abort_busy",   32'({busy1, busy2}), 32'd0);
    chk("abort_done",   32'({done1, done2}), 32'd0);
    chk("abort_result", 32'({res1, res2}),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      if (done1 || done2 || busy1 || busy2) nd++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    run(8'h5C, 8'h5C, 2'b00, 1'b0);

    // Randomized patterns, modes and START re-pulsing.
    for (int r = 0; r < 8; r++) begin
      rp  = 8'($urandom);
      rjk = 2'($urandom_range(0, 3));
      run(rp, (r % 2 == 0) ? rp : 8'($urandom), rjk, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
